// File: rtl/prbs3_pkg.sv
// Shared definitions for the 3-bit PRBS checker: FSM states, recurrence taps,
// the generator seed and the sequence period.
package prbs3_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // s[n] = s[n-2] ^ s[n-3]; hist[0] is the newest sample
  localparam int          PRBS3_TAP_A  = 1;
  localparam int          PRBS3_TAP_B  = 2;
  localparam logic [2:0]  PRBS3_SEED   = 3'b111;
  localparam int          PRBS3_PERIOD = 7;

  function automatic logic prbs3_predict(input logic [2:0] h);
    return h[PRBS3_TAP_A] ^ h[PRBS3_TAP_B];
  endfunction

endpackage

// File: rtl/prbs3_ref_gen.sv
// History/prediction register for the PRBS3 checker; loads either the line
// bit (while acquiring) or its own prediction (free-running local generator).
module prbs3_ref_gen
  import prbs3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift_din,
  input  logic       shift_pred,
  input  logic       din,
  output logic [2:0] hist,
  output logic       pred
);

  logic [2:0] hist_reg;
  logic [2:0] hist_next;

  assign pred         = prbs3_predict(hist_reg);
  assign hist_next[0] = shift_din ? din : pred;

  genvar gi;
  generate
    for (gi = 1; gi < 3; gi++) begin : g_shift
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
    end else if (shift_din || shift_pred) begin
      hist_reg <= hist_next;
    end
  end

  assign hist = hist_reg;

endmodule

// File: rtl/prbs3_checker.sv
// Self-synchronising PRBS3 checker: SEED -> HUNT -> LOCKED with error pulse,
// loss-of-lock and an optional saturating error counter (PRBS3_CHK_ERRCNT_EN).
module prbs3_checker
  import prbs3_pkg::*;
#(
  parameter int LOCK_CNT   = 7,
  parameter int UNLOCK_ERR = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_ERR);

  state_t     state_reg;
  logic [1:0] seed_cnt_reg;
  logic [3:0] match_cnt_reg;
  logic [3:0] err_run_reg;
  logic [2:0] hist;
  logic       pred;
  logic       miss;
  logic       hist_zero;
  logic       new_err;
  logic       unlock;

  assign miss      = din ^ pred;
  assign hist_zero = (hist == 3'b000);
  assign new_err   = din_valid && (state_reg == LOCKED) && miss;
  assign unlock    = new_err && ((err_run_reg + 4'd1) == UNLOCK_LIM);

  prbs3_ref_gen u_ref_gen (
    .clk        (clk),
    .reset      (reset),
    .clr        (unlock),
    .shift_din  (din_valid && (state_reg != LOCKED)),
    .shift_pred (din_valid && (state_reg == LOCKED)),
    .din        (din),
    .hist       (hist),
    .pred       (pred)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SEED;
      seed_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      err_run_reg   <= '0;
      locked        <= 1'b0;
      err           <= 1'b0;
    end else begin
      err <= new_err;
      if (din_valid) begin
        unique case (state_reg)
          SEED: begin
            if (seed_cnt_reg == 2'd2) begin
              seed_cnt_reg <= '0;
              state_reg    <= HUNT;
            end else begin
              seed_cnt_reg <= seed_cnt_reg + 2'd1;
            end
          end
          HUNT: begin
            // an all-zero history must never count, or a dead line would lock
            if (!miss && !hist_zero) begin
              if ((match_cnt_reg + 4'd1) == LOCK_LIM) begin
                match_cnt_reg <= '0;
                state_reg     <= LOCKED;
                locked        <= 1'b1;
              end else begin
                match_cnt_reg <= match_cnt_reg + 4'd1;
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            if (miss) begin
              if (unlock) begin
                state_reg     <= SEED;
                match_cnt_reg <= '0;
                err_run_reg   <= '0;
                locked        <= 1'b0;
              end else begin
                err_run_reg <= err_run_reg + 4'd1;
              end
            end else begin
              err_run_reg <= '0;
            end
          end
          default: state_reg <= SEED;
        endcase
      end
    end
  end

`ifdef PRBS3_CHK_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= new_err ? CNT_W'(1) : '0;
    end else if (new_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule
